// File: rtl/axil_sorter_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : axil_sorter_fifo
//  Purpose  : AXI4-Lite write slave that classifies DATA words by header
//             byte (sync/mask) and sorts them into valid/invalid FWFT FIFOs.
//  Revision : 1.0 - initial release
// ============================================================================
module axil_sorter_fifo #(
    parameter int ADDR_W = 32,
    parameter int WIDTH  = 32,
    parameter int DEPTH  = 8,
    parameter int CW     = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] AWADDR,
    input  logic              AWVALID,
    output logic              AWREADY,
    input  logic [31:0]       WDATA,
    input  logic [3:0]        WSTRB,
    input  logic              WVALID,
    output logic              WREADY,
    output logic [1:0]        BRESP,
    output logic              BVALID,
    input  logic              BREADY,
    input  logic              val_rd_en,
    output logic [WIDTH-1:0]  val_rd_data,
    output logic              val_full,
    output logic              val_empty,
    output logic [CW-1:0]     val_count,
    input  logic              ival_rd_en,
    output logic [WIDTH-1:0]  ival_rd_data,
    output logic              ival_full,
    output logic              ival_empty,
    output logic [CW-1:0]     ival_count,
    output logic [15:0]       drop_cnt
);

    localparam int         PW       = $clog2(DEPTH);
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCEPT = 2'd1;
    localparam logic [1:0] S_RESP   = 2'd2;
    localparam logic [1:0] C_OKAY   = 2'b00;
    localparam logic [1:0] C_SLVERR = 2'b10;

    logic [1:0]  r_state;
    logic        r_awready;
    logic        r_wready;
    logic        r_bvalid;
    logic [1:0]  r_bresp;
    logic        r_enable;
    logic [7:0]  r_sync;
    logic [7:0]  r_mask;
    logic [15:0] r_drop_cnt;

    logic        w_accept;
    logic        w_is_ctrl;
    logic        w_is_match;
    logic        w_is_data;
    logic        w_cls_valid;
    logic        w_tgt_full;
    logic        w_data_ok;
    logic        w_drop;
    logic [1:0]  w_resp;
    logic        w_unused;

    // Index 0 is the valid FIFO, index 1 the invalid FIFO.
    logic [1:0]             w_push;
    logic [1:0]             w_pop;
    logic [1:0]             w_full;
    logic [1:0]             w_empty;
    logic [1:0]             w_rd_en;
    logic [1:0][CW-1:0]     w_count;
    logic [1:0][WIDTH-1:0]  w_rd_data;

    assign w_unused    = ^{WSTRB, WDATA};
    assign w_accept    = (r_state == S_ACCEPT);
    assign w_is_ctrl   = (AWADDR == ADDR_W'(32'h0));
    assign w_is_match  = (AWADDR == ADDR_W'(32'h4));
    assign w_is_data   = (AWADDR == ADDR_W'(32'h8));
    assign w_cls_valid = (((WDATA[31:24] ^ r_sync) & r_mask) == 8'h00);
    assign w_tgt_full  = w_cls_valid ? w_full[0] : w_full[1];
    assign w_data_ok   = w_accept && w_is_data && r_enable && !w_tgt_full;
    assign w_drop      = w_accept && w_is_data && r_enable && w_tgt_full;
    assign w_push[0]   = w_data_ok && w_cls_valid;
    assign w_push[1]   = w_data_ok && !w_cls_valid;
    assign w_rd_en     = {ival_rd_en, val_rd_en};

    always_comb begin
        w_resp = C_SLVERR;
        if (w_is_ctrl || w_is_match) begin
            w_resp = C_OKAY;
        end else if (w_is_data && r_enable && !w_tgt_full) begin
            w_resp = C_OKAY;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_awready  <= 1'b0;
            r_wready   <= 1'b0;
            r_bvalid   <= 1'b0;
            r_bresp    <= C_OKAY;
            r_enable   <= 1'b1;
            r_sync     <= 8'hA5;
            r_mask     <= 8'hFF;
            r_drop_cnt <= 16'h0000;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (AWVALID && WVALID) begin
                        r_state   <= S_ACCEPT;
                        r_awready <= 1'b1;
                        r_wready  <= 1'b1;
                    end
                end
                S_ACCEPT: begin
                    r_awready <= 1'b0;
                    r_wready  <= 1'b0;
                    r_bvalid  <= 1'b1;
                    r_bresp   <= w_resp;
                    r_state   <= S_RESP;
                    if (w_is_ctrl) begin
                        r_enable <= WDATA[0];
                    end
                    if (w_is_match) begin
                        r_sync <= WDATA[7:0];
                        r_mask <= WDATA[15:8];
                    end
                    if (w_drop && (r_drop_cnt != 16'hFFFF)) begin
                        r_drop_cnt <= r_drop_cnt + 16'd1;
                    end
                end
                S_RESP: begin
                    if (BREADY) begin
                        r_bvalid <= 1'b0;
                        r_state  <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    for (genvar f = 0; f < 2; f++) begin : g_fifo
        logic [WIDTH-1:0] r_mem [DEPTH];
        logic [PW-1:0]    r_wptr;
        logic [PW-1:0]    r_rptr;
        logic [CW-1:0]    r_count;

        assign w_full[f]    = (r_count == CW'(DEPTH));
        assign w_empty[f]   = (r_count == '0);
        assign w_pop[f]     = w_rd_en[f] && !w_empty[f];
        assign w_count[f]   = r_count;
        assign w_rd_data[f] = r_mem[r_rptr];

        always_ff @(posedge clk) begin
            if (rst) begin
                r_wptr  <= '0;
                r_rptr  <= '0;
                r_count <= '0;
            end else begin
                if (w_push[f]) begin
                    r_wptr <= r_wptr + 1'b1;
                end
                if (w_pop[f]) begin
                    r_rptr <= r_rptr + 1'b1;
                end
                case ({w_push[f], w_pop[f]})
                    2'b10:   r_count <= r_count + 1'b1;
                    2'b01:   r_count <= r_count - 1'b1;
                    default: r_count <= r_count;
                endcase
            end
        end

        // Storage is intentionally left out of reset.
        always_ff @(posedge clk) begin
            if (w_push[f]) begin
                r_mem[r_wptr] <= WDATA[WIDTH-1:0];
            end
        end
    end

    assign AWREADY      = r_awready;
    assign WREADY       = r_wready;
    assign BVALID       = r_bvalid;
    assign BRESP        = r_bresp;
    assign drop_cnt     = r_drop_cnt;
    assign val_rd_data  = w_rd_data[0];
    assign val_full     = w_full[0];
    assign val_empty    = w_empty[0];
    assign val_count    = w_count[0];
    assign ival_rd_data = w_rd_data[1];
    assign ival_full    = w_full[1];
    assign ival_empty   = w_empty[1];
    assign ival_count   = w_count[1];

endmodule
`default_nettype wire
